dmem_arbiter: RTL and testbench

//  Shares the single data-memory port between the core and the UART engine.

---
 rtl/dmem_arbiter_pkg.sv | 22 ++
 rtl/dmem_arbiter_wait_counter.sv | 31 +++
 rtl/dmem_arbiter.sv | 147 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and owner-state encoding for the data-memory arbiter.
// Imported by dmem_arbiter and arb_wait_counter.
package dmem_arbiter_pkg;

    localparam int WORD_LEN     = 32;
    localparam int ARB_MAX_WAIT = 8;
    localparam int ARB_WAIT_W   = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CORE = 2'd1,
        ARB_UART = 2'd2
    } arb_state_e;

    function automatic logic is_owner(
        input arb_state_e st,
        input arb_state_e who
    );
        return st == who;
    endfunction

endpackage

// File: rtl/dmem_arbiter_wait_counter.sv
// Saturating wait counter used by the arbiter starvation guard.
// Clear has priority over increment; sat flags cnt >= MAX.
module arb_wait_counter
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX = ARB_MAX_WAIT,
    parameter int W   = ARB_WAIT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    assign sat = (cnt >= MAX_V);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between core and UART with starvation guard.
// Define DMEM_ARB_STATS_EN to add wrap-around statistics counters/ports.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int WORD_LEN = dmem_arbiter_pkg::WORD_LEN,
    parameter int MAX_WAIT = ARB_MAX_WAIT,
    parameter int WAIT_W   = ARB_WAIT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                core_req,
    input  logic [WORD_LEN-1:0] core_addr,
    input  logic                core_wen,
    input  logic [WORD_LEN-1:0] core_wdata,
    output logic [WORD_LEN-1:0] core_rdata,
    output logic                core_stall,
    input  logic                uart_req,
    input  logic                uart_lock,
    input  logic [WORD_LEN-1:0] uart_addr,
    input  logic                uart_wen,
    input  logic [WORD_LEN-1:0] uart_wdata,
    output logic                uart_gnt,
    output logic [WORD_LEN-1:0] uart_rdata,
`ifdef DMEM_ARB_STATS_EN
    output logic [31:0]         stat_core_stall_cyc,
    output logic [31:0]         stat_uart_beats,
    output logic [31:0]         stat_starve_evt,
`endif
    output logic [WORD_LEN-1:0] mem_addr,
    output logic                mem_wen,
    output logic [WORD_LEN-1:0] mem_wdata,
    input  logic [WORD_LEN-1:0] mem_rdata
);

    arb_state_e         state_q;
    arb_state_e         state_d;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               wait_sat;
    logic               wait_clr;
    logic               in_core;
    logic               in_uart;
    logic               starve;

    assign in_core = is_owner(state_q, ARB_CORE);
    assign in_uart = is_owner(state_q, ARB_UART);

    assign core_stall = core_req & ~in_core;
    assign uart_gnt   = in_uart & uart_req;
    assign core_rdata = mem_rdata;
    assign uart_rdata = mem_rdata;

    assign wait_clr = in_core | ~core_req;

    arb_wait_counter #(
        .MAX (MAX_WAIT),
        .W   (WAIT_W)
    ) u_wait (
        .clk (clk),
        .rst (rst),
        .clr (wait_clr),
        .inc (core_stall),
        .cnt (wait_cnt),
        .sat (wait_sat)
    );

    // A locked burst is never preempted; otherwise a saturated wait forces CORE.
    assign starve = in_uart & ~(uart_req & uart_lock) & core_req & wait_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ARB_IDLE;
        unique case (state_q)
            ARB_IDLE, ARB_CORE: begin
                if (uart_req) begin
                    state_d = ARB_UART;
                end else if (core_req) begin
                    state_d = ARB_CORE;
                end
            end
            ARB_UART: begin
                if (uart_req && uart_lock) begin
                    state_d = ARB_UART;
                end else if (starve) begin
                    state_d = ARB_CORE;
                end else if (uart_req) begin
                    state_d = ARB_UART;
                end else if (core_req) begin
                    state_d = ARB_CORE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Only the registered owner's inputs reach the memory port.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wen   = 1'b0;
        unique case (state_q)
            ARB_CORE: begin
                mem_addr  = core_addr;
                mem_wdata = core_wdata;
                mem_wen   = core_wen & core_req;
            end
            ARB_UART: begin
                mem_addr  = uart_addr;
                mem_wdata = uart_wdata;
                mem_wen   = uart_wen & uart_req;
            end
            default: begin
                mem_addr  = '0;
                mem_wdata = '0;
                mem_wen   = 1'b0;
            end
        endcase
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_core_stall_cyc <= '0;
            stat_uart_beats     <= '0;
            stat_starve_evt     <= '0;
        end else begin
            if (core_stall) begin
                stat_core_stall_cyc <= stat_core_stall_cyc + 32'd1;
            end
            if (uart_gnt) begin
                stat_uart_beats <= stat_uart_beats + 32'd1;
            end
            if (starve) begin
                stat_starve_evt <= stat_starve_evt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: owner model plus directed vectors.
// Works with or without DMEM_ARB_STATS_EN.
module tb_dmem_arbiter;

    localparam int W  = 32;
    localparam int MW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          core_req, core_wen, uart_req, uart_lock, uart_wen;
    logic [W-1:0]  core_addr, core_wdata, uart_addr, uart_wdata;
    logic [W-1:0]  core_rdata, uart_rdata, mem_addr, mem_wdata, mem_rdata;
    logic          core_stall, uart_gnt, mem_wen;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0]   stat_core_stall_cyc, stat_uart_beats, stat_starve_evt;
    logic [31:0]   m_st_stall = 0, m_st_beats = 0, m_st_starve = 0;
`endif

    logic [31:0]   mem_arr [0:1023];

    int n_cmp = 0;
    int n_bad = 0;

    // Model: 0 = nobody owns, 1 = core owns, 2 = UART owns.
    int m_own  = 0;
    int m_wait = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.WORD_LEN(W), .MAX_WAIT(MW), .WAIT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_addr  (core_addr),
        .core_wen   (core_wen),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .uart_req   (uart_req),
        .uart_lock  (uart_lock),
        .uart_addr  (uart_addr),
        .uart_wen   (uart_wen),
        .uart_wdata (uart_wdata),
        .uart_gnt   (uart_gnt),
        .uart_rdata (uart_rdata),
`ifdef DMEM_ARB_STATS_EN
        .stat_core_stall_cyc (stat_core_stall_cyc),
        .stat_uart_beats     (stat_uart_beats),
        .stat_starve_evt     (stat_starve_evt),
`endif
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    assign mem_rdata = mem_arr[mem_addr[11:2]];

    always @(posedge clk) begin
        if (mem_wen) mem_arr[mem_addr[11:2]] <= mem_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int f_next(int own, int w, bit cr, bit ur, bit ul);
        if (own == 2) begin
            if (ur && ul) return 2;
            if (cr && w >= MW) return 1;
        end
        if (ur) return 2;
        if (cr) return 1;
        return 0;
    endfunction

    function automatic int f_wait(int own, int w, bit cr);
        if (own == 1 || !cr) return 0;
        return (w + 1 > MW) ? MW : w + 1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_own  <= 0;
            m_wait <= 0;
`ifdef DMEM_ARB_STATS_EN
            m_st_stall  <= 0;
            m_st_beats  <= 0;
            m_st_starve <= 0;
`endif
        end else begin
            m_own  <= f_next(m_own, m_wait, core_req, uart_req, uart_lock);
            m_wait <= f_wait(m_own, m_wait, core_req);
`ifdef DMEM_ARB_STATS_EN
            if (core_req && m_own != 1) m_st_stall <= m_st_stall + 1;
            if (uart_req && m_own == 2) m_st_beats <= m_st_beats + 1;
            if (m_own == 2 && !(uart_req && uart_lock) && core_req && m_wait >= MW)
                m_st_starve <= m_st_starve + 1;
`endif
        end
    end

    always @(negedge clk) begin
        chk("core_stall", 32'(core_stall), 32'(core_req && m_own != 1));
        chk("uart_gnt", 32'(uart_gnt), 32'(uart_req && m_own == 2));
        chk("mem_addr", mem_addr,
            m_own == 1 ? core_addr : m_own == 2 ? uart_addr : 32'd0);
        chk("mem_wdata", mem_wdata,
            m_own == 1 ? core_wdata : m_own == 2 ? uart_wdata : 32'd0);
        chk("mem_wen", 32'(mem_wen),
            32'(m_own == 1 ? core_wen && core_req :
                m_own == 2 ? uart_wen && uart_req : 1'b0));
        chk("core_rdata", core_rdata, mem_arr[mem_addr[11:2]]);
        chk("uart_rdata", uart_rdata, mem_arr[mem_addr[11:2]]);
`ifdef DMEM_ARB_STATS_EN
        chk("stat_stall", stat_core_stall_cyc, m_st_stall);
        chk("stat_beats", stat_uart_beats, m_st_beats);
        chk("stat_starve", stat_starve_evt, m_st_starve);
`endif
    end

    task automatic cyc(input bit cr, input logic [31:0] ca, input bit cw,
                       input logic [31:0] cd, input bit ur, input bit ul,
                       input logic [31:0] ua, input bit uw,
                       input logic [31:0] ud);
        @(posedge clk);
        #1;
        core_req = cr; core_addr = ca; core_wen = cw; core_wdata = cd;
        uart_req = ur; uart_lock = ul; uart_addr = ua; uart_wen = uw;
        uart_wdata = ud;
        #3;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int gnts;
        int runs;
        for (int i = 0; i < 1024; i++) mem_arr[i] = 32'd0;
        core_req = 0; core_addr = 0; core_wen = 0; core_wdata = 0;
        uart_req = 0; uart_lock = 0; uart_addr = 0; uart_wen = 0;
        uart_wdata = 0;
        rst = 1;
        idle();
        idle();
        rst = 0;

        // Core-only access
        for (int i = 0; i < 4; i++) begin
            cyc(1, 32'h100 + 32'(4 * i), 0, 0, 0, 0, 0, 0, 0);
            if (i == 0) begin
                chk("s1_rst_stall", 32'(core_stall), 1);
                chk("s1_rst_addr", mem_addr, 0);
                chk("s1_rst_wen", 32'(mem_wen), 0);
            end else begin
                chk("s1_stall", 32'(core_stall), 0);
                chk("s1_addr", mem_addr, 32'h100 + 32'(4 * i));
            end
        end
        idle();
        idle();

        // Simultaneous request, two UART beats
        gnts = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1, 32'h300, 1, 32'h11, i < 3, 0, 32'h304, 1, 32'h22);
            if (i < 4) gnts += int'(uart_gnt);
            if (i == 1) chk("s2_uaddr", mem_addr, 32'h304);
            if (i == 4) begin
                chk("s2_stall", 32'(core_stall), 0);
                chk("s2_caddr", mem_addr, 32'h300);
            end
        end
        chk("s2_gnts", 32'(gnts), 2);
        idle();

        // UART streaming unlocked; core must get through every 8 waits
        gnts = 0;
        runs = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1, 32'h380, 0, 0, 1, 0, 32'h400 + 32'(4 * i), 0, 0);
            gnts += int'(uart_gnt);
            runs += int'(!core_stall);
            if (i == 9) chk("s3_core_in", 32'(core_stall), 0);
            if (i == 10) chk("s3_uart_back", 32'(uart_gnt), 1);
        end
        chk("s3_gnts", 32'(gnts), 17);
        chk("s3_core_runs", 32'(runs), 2);
        idle();

        // Locked burst: no preemption even with saturated wait
        gnts = 0;
        runs = 0;
        for (int i = 0; i < 14; i++) begin
            cyc(1, 32'h380, 0, 0, 1, i < 12, 32'h480, 0, 0);
            if (i < 13) begin
                gnts += int'(uart_gnt);
                runs += int'(core_stall);
            end else begin
                chk("s4_core_in", 32'(core_stall), 0);
                chk("s4_no_gnt", 32'(uart_gnt), 0);
            end
        end
        chk("s4_gnts", 32'(gnts), 12);
        chk("s4_stalls", 32'(runs), 13);
        idle();

        // Reset in the middle of a locked write burst
        cyc(1, 32'h380, 0, 0, 1, 1, 32'h500, 1, 32'h55);
        cyc(1, 32'h380, 0, 0, 1, 1, 32'h500, 1, 32'h55);
        chk("s5_wen_pre", 32'(mem_wen), 1);
        rst = 1;
        cyc(1, 32'h380, 0, 0, 1, 1, 32'h500, 1, 32'h55);
        chk("s5_wen", 32'(mem_wen), 0);
        chk("s5_gnt", 32'(uart_gnt), 0);
        chk("s5_addr", mem_addr, 0);
        chk("s5_stall", 32'(core_stall), 1);
`ifdef DMEM_ARB_STATS_EN
        chk("s5_st_stall", stat_core_stall_cyc, 0);
        chk("s5_st_beats", stat_uart_beats, 0);
        chk("s5_st_starve", stat_starve_evt, 0);
`endif
        rst = 0;
        idle();
        idle();

        // Core write then UART read-back
        cyc(1, 32'h200, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        cyc(1, 32'h200, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        chk("s6_cwen", 32'(mem_wen), 1);
        cyc(0, 0, 0, 0, 1, 0, 32'h200, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 32'h200, 0, 0);
        chk("s6_gnt", 32'(uart_gnt), 1);
        chk("s6_rdata", uart_rdata, 32'hDEADBEEF);
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
